// File: rtl/seq_load_buffer.sv
// Sequence load buffer: fills NUM_SEQS letter sequences from a valid/ready beat stream,
// holds them stable for the PU array and serves aligned letter-group reads.
module seq_load_buffer #(
    parameter int SEQ_LENGTH   = 32,
    parameter int LETTER_WIDTH = 2,
    parameter int INPUT_WIDTH  = 8,
    parameter int NUM_SEQS     = 2,
    parameter int RD_LETTERS   = 2,
    localparam int SEQ_W       = (NUM_SEQS > 1) ? $clog2(NUM_SEQS) : 1,
    localparam int IDX_W       = $clog2(SEQ_LENGTH),
    localparam int FLAT_W      = NUM_SEQS * SEQ_LENGTH * LETTER_WIDTH,
    localparam int RD_W        = RD_LETTERS * LETTER_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   flush,
    input  logic [INPUT_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   seq_valid,
    output logic [FLAT_W-1:0]      seq_flat,
    input  logic                   consume,
    input  logic                   rd_en,
    input  logic [SEQ_W-1:0]       rd_seq,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [RD_W-1:0]        rd_data,
    output logic                   rd_valid,
    output logic                   busy
);
    localparam int BEATS  = SEQ_LENGTH * LETTER_WIDTH / INPUT_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int GROUPS = SEQ_LENGTH / RD_LETTERS;
    localparam int SEQ_BITS = SEQ_LENGTH * LETTER_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [SEQ_W-1:0]  seq_cnt;
    logic [FLAT_W-1:0] storage;
    logic [RD_W-1:0]   rd_word;
    logic              rd_ok;

    assign in_ready  = (state == LOAD);
    assign seq_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign seq_flat  = storage;

    // Only in-range, group-aligned requests match a slot, so rd_ok doubles as the legality check.
    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b0;
        for (int unsigned s = 0; s < NUM_SEQS; s++) begin
            for (int unsigned g = 0; g < GROUPS; g++) begin
                if (32'(rd_seq) == s && 32'(rd_idx) == g * RD_LETTERS) begin
                    rd_ok   = 1'b1;
                    rd_word = storage[s*SEQ_BITS + g*RD_W +: RD_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            seq_cnt  <= '0;
            storage  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (rd_en && state == HOLD && rd_ok) begin
                rd_valid <= 1'b1;
                rd_data  <= rd_word;
            end

            if (flush) begin
                state    <= IDLE;
                beat_cnt <= '0;
                seq_cnt  <= '0;
                storage  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= LOAD;
                            beat_cnt <= '0;
                            seq_cnt  <= '0;
                            storage  <= '0;
                        end
                    end
                    LOAD: begin
                        if (in_valid) begin
                            for (int unsigned s = 0; s < NUM_SEQS; s++) begin
                                for (int unsigned b = 0; b < BEATS; b++) begin
                                    if (32'(seq_cnt) == s && 32'(beat_cnt) == b)
                                        storage[s*SEQ_BITS + b*INPUT_WIDTH +: INPUT_WIDTH] <= in_data;
                                end
                            end
                            if (32'(beat_cnt) == 32'(BEATS - 1)) begin
                                beat_cnt <= '0;
                                if (32'(seq_cnt) == 32'(NUM_SEQS - 1)) begin
                                    seq_cnt <= '0;
                                    state   <= HOLD;
                                end else begin
                                    seq_cnt <= seq_cnt + 1'b1;
                                end
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (consume)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seq_load_buffer.sv
// Self-checking bench for seq_load_buffer: directed table, hand-written corner sequences,
// and random stimulus against a letter-array reference model.
module tb_seq_load_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic         start_a = 0, flush_a = 0, in_valid_a = 0, consume_a = 0, rd_en_a = 0;
    logic [7:0]   in_data_a = '0;
    logic [0:0]   rd_seq_a = '0;
    logic [4:0]   rd_idx_a = '0;
    logic         in_ready_a, seq_valid_a, busy_a, rd_valid_a;
    logic [127:0] seq_flat_a;
    logic [3:0]   rd_data_a;

    // wide instance: 64 letters, 4 sequences, 16-bit beats
    logic         start_b = 0, flush_b = 0, in_valid_b = 0, consume_b = 0, rd_en_b = 0;
    logic [15:0]  in_data_b = '0;
    logic [1:0]   rd_seq_b = '0;
    logic [5:0]   rd_idx_b = '0;
    logic         in_ready_b, seq_valid_b, busy_b, rd_valid_b;
    logic [511:0] seq_flat_b;
    logic [3:0]   rd_data_b;

    seq_load_buffer dut_a (
        .clk(clk), .rst(rst), .start(start_a), .flush(flush_a), .in_data(in_data_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .seq_valid(seq_valid_a),
        .seq_flat(seq_flat_a), .consume(consume_a), .rd_en(rd_en_a), .rd_seq(rd_seq_a),
        .rd_idx(rd_idx_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .busy(busy_a)
    );

    seq_load_buffer #(.SEQ_LENGTH(64), .NUM_SEQS(4), .INPUT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .flush(flush_b), .in_data(in_data_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .seq_valid(seq_valid_b),
        .seq_flat(seq_flat_b), .consume(consume_b), .rd_en(rd_en_b), .rd_seq(rd_seq_b),
        .rd_idx(rd_idx_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        start_a = 0; flush_a = 0; in_valid_a = 0; consume_a = 0; rd_en_a = 0;
    endtask

    typedef struct {
        logic       start, consume, in_valid, rd_en;
        logic [7:0] data;
        logic [0:0] rseq;
        logic [4:0] ridx;
        logic       e_ready, e_sval, e_busy, e_rval;
        logic [3:0] e_rdata;
    } vec_t;

    vec_t tbl[23];

    // reference model state for the default instance
    logic [1:0]   m_mem[64];
    int           m_mode;   // 0 idle, 1 loading, 2 holding
    int           m_cnt;    // beats accepted in current job
    logic         m_rv;
    logic [3:0]   m_rd;

    function automatic logic [511:0] model_flat();
        logic [511:0] f = '0;
        for (int i = 0; i < 64; i++) f[i*2 +: 2] = m_mem[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_mem[i] = 2'b00;
        m_cnt = 0;
    endtask

    task automatic model_step();
        int s, idx;
        s = int'(rd_seq_a);
        idx = int'(rd_idx_a);
        if (rd_en_a && m_mode == 2 && idx % 2 == 0) begin
            m_rv = 1'b1;
            m_rd = {m_mem[s*32 + idx + 1], m_mem[s*32 + idx]};
        end else begin
            m_rv = 1'b0;
        end
        if (flush_a) begin
            m_mode = 0;
            model_clear();
        end else if (m_mode == 0) begin
            if (start_a) begin
                m_mode = 1;
                model_clear();
            end
        end else if (m_mode == 1) begin
            if (in_valid_a) begin
                for (int k = 0; k < 4; k++)
                    m_mem[(m_cnt / 8) * 32 + (m_cnt % 8) * 4 + k] = in_data_a[k*2 +: 2];
                m_cnt++;
                if (m_cnt == 16) m_mode = 2;
            end
        end else if (consume_a) begin
            m_mode = 0;
        end
    endtask

    logic [127:0] exp_a;
    logic [511:0] exp_b;
    logic [7:0]   job[16];
    int           beats, cyc;

    initial begin
        // directed table: load, reads incl. misaligned, start ignored in HOLD, consume+read
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
        for (int i = 1; i <= 16; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, (i <= 8) ? 8'h1B : 8'hE4, 1'b0, 5'd0,
                       (i < 16), (i == 16), 1'b1, 1'b0, 4'h0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, 4'hE};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'hE};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hB};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hB};
        tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4};
        exp_a = {{8{8'hE4}}, {8{8'h1B}}};

        #1 rst = 1'b1;
        #1;
        chk("reset in_ready", 512'(in_ready_a), 512'(0));
        chk("reset seq_valid", 512'(seq_valid_a), 512'(0));
        chk("reset busy", 512'(busy_a), 512'(0));
        chk("reset rd_valid", 512'(rd_valid_a), 512'(0));
        chk("reset rd_data", 512'(rd_data_a), 512'(0));
        chk("reset seq_flat", 512'(seq_flat_a), 512'(0));
        tick();
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            start_a = tbl[i].start; consume_a = tbl[i].consume; in_valid_a = tbl[i].in_valid;
            rd_en_a = tbl[i].rd_en; in_data_a = tbl[i].data;
            rd_seq_a = tbl[i].rseq; rd_idx_a = tbl[i].ridx;
            tick();
            chk($sformatf("tbl%0d in_ready", i), 512'(in_ready_a), 512'(tbl[i].e_ready));
            chk($sformatf("tbl%0d seq_valid", i), 512'(seq_valid_a), 512'(tbl[i].e_sval));
            chk($sformatf("tbl%0d busy", i), 512'(busy_a), 512'(tbl[i].e_busy));
            chk($sformatf("tbl%0d rd_valid", i), 512'(rd_valid_a), 512'(tbl[i].e_rval));
            chk($sformatf("tbl%0d rd_data", i), 512'(rd_data_a), 512'(tbl[i].e_rdata));
            if (i == 16 || i == 20)
                chk($sformatf("tbl%0d seq_flat", i), 512'(seq_flat_a), 512'(exp_a));
        end
        clear_a();

        // same job with in_valid toggling every other cycle
        start_a = 1; tick(); start_a = 0;
        beats = 0; cyc = 0;
        while (beats < 16 && cyc < 64) begin
            in_valid_a = cyc[0];
            in_data_a = (beats < 8) ? 8'h1B : 8'hE4;
            tick();
            if (in_valid_a) beats++;
            chk("gap in_ready", 512'(in_ready_a), 512'(beats < 16));
            chk("gap seq_valid", 512'(seq_valid_a), 512'(beats == 16));
            cyc++;
        end
        in_valid_a = 0;
        chk("gap beats done", 512'(beats), 512'(16));
        chk("gap seq_flat", 512'(seq_flat_a), 512'(exp_a));
        consume_a = 1; tick(); consume_a = 0;
        chk("consume busy", 512'(busy_a), 512'(0));

        // flush after 5 beats, then a fresh job
        start_a = 1; tick(); start_a = 0;
        in_valid_a = 1; in_data_a = 8'hA5;
        repeat (5) tick();
        in_valid_a = 0; flush_a = 1; tick(); flush_a = 0;
        chk("flush busy", 512'(busy_a), 512'(0));
        chk("flush in_ready", 512'(in_ready_a), 512'(0));
        chk("flush seq_flat", 512'(seq_flat_a), 512'(0));
        start_a = 1; tick(); start_a = 0;
        exp_a = '0;
        for (int i = 0; i < 16; i++) begin
            job[i] = 8'($urandom);
            exp_a[i*8 +: 8] = job[i];
            in_valid_a = 1; in_data_a = job[i];
            tick();
        end
        in_valid_a = 0;
        chk("reload seq_valid", 512'(seq_valid_a), 512'(1));
        chk("reload seq_flat", 512'(seq_flat_a), 512'(exp_a));
        consume_a = 1; tick(); consume_a = 0;

        // wide instance: async reset mid-load, then a full 32-beat job
        start_b = 1; tick(); start_b = 0;
        in_valid_b = 1; in_data_b = 16'hBEEF;
        repeat (10) tick();
        in_valid_b = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst busy", 512'(busy_b), 512'(0));
        chk("arst in_ready", 512'(in_ready_b), 512'(0));
        chk("arst seq_valid", 512'(seq_valid_b), 512'(0));
        chk("arst seq_flat", 512'(seq_flat_b), 512'(0));
        chk("arst rd_valid", 512'(rd_valid_b), 512'(0));
        tick();
        rst = 1'b0;
        start_b = 1; tick(); start_b = 0;
        exp_b = '0;
        for (int i = 0; i < 32; i++) begin
            in_data_b = 16'($urandom);
            exp_b[i*16 +: 16] = in_data_b;
            in_valid_b = 1;
            tick();
            if (i == 30) chk("wide seq_valid early", 512'(seq_valid_b), 512'(0));
        end
        in_valid_b = 0;
        chk("wide seq_valid", 512'(seq_valid_b), 512'(1));
        chk("wide seq_flat", seq_flat_b, exp_b);
        rd_en_b = 1; rd_seq_b = 2'd3; rd_idx_b = 6'd6; tick();
        chk("wide rd_valid", 512'(rd_valid_b), 512'(1));
        chk("wide rd_data", 512'(rd_data_b), 512'(exp_b[396 +: 4]));
        rd_idx_b = 6'd5; tick(); rd_en_b = 0;
        chk("wide misaligned rd_valid", 512'(rd_valid_b), 512'(0));

        // random stimulus against the reference model
        clear_a();
        rst = 1'b1; tick(); rst = 1'b0;
        m_mode = 0; m_rv = 1'b0; m_rd = 4'h0;
        model_clear();
        for (int n = 0; n < 3000; n++) begin
            start_a    = ($urandom_range(0, 9) == 0);
            flush_a    = ($urandom_range(0, 49) == 0);
            in_valid_a = ($urandom_range(0, 9) < 6);
            in_data_a  = 8'($urandom);
            consume_a  = ($urandom_range(0, 19) == 0);
            rd_en_a    = ($urandom_range(0, 1) == 1);
            rd_seq_a   = 1'($urandom);
            rd_idx_a   = 5'($urandom_range(0, 31));
            model_step();
            tick();
            chk("rand in_ready", 512'(in_ready_a), 512'(m_mode == 1));
            chk("rand seq_valid", 512'(seq_valid_a), 512'(m_mode == 2));
            chk("rand busy", 512'(busy_a), 512'(m_mode != 0));
            chk("rand rd_valid", 512'(rd_valid_a), 512'(m_rv));
            chk("rand rd_data", 512'(rd_data_a), 512'(m_rd));
            chk("rand seq_flat", 512'(seq_flat_a), model_flat());
        end
        clear_a();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
